// File: rtl/lu_arbiter.sv
// lu_arbiter: shared WIDTH-bit bitwise logic unit (NAND/AND/OR/NOR) serving
// two requesters through valid/ready handshakes, with round-robin arbitration.
//
// Ports:
//   clk, rst_n                     clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready        requester N handshake (N = 0, 1)
//   reqN_a, reqN_b                 requester N operands (WIDTH bits)
//   reqN_op                        00 NAND, 01 AND, 10 OR, 11 NOR
//   res_valid / res_ready          result handshake towards the consumer
//   res_data                       registered result (WIDTH bits)
//   res_id                         requester that owns res_data
module lu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t           state;
    logic             ptr;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic             id_q;
    logic             grant_id;
    logic [WIDTH-1:0] result;

    // The pointer only breaks ties; a lone requester is always the grant.
    // Readys are gated by rst_n so they stay low while reset is asserted.
    always_comb begin
        grant_id   = (req0_valid && req1_valid) ? ptr : req1_valid;
        req0_ready = rst_n && (state == IDLE) && req0_valid && !grant_id;
        req1_ready = rst_n && (state == IDLE) && req1_valid && grant_id;
    end

    always_comb begin
        result = '0;
        case (op_q)
            2'b00:   result = ~(a_q & b_q);
            2'b01:   result = a_q & b_q;
            2'b10:   result = a_q | b_q;
            default: result = ~(a_q | b_q);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            id_q      <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        a_q   <= grant_id ? req1_a  : req0_a;
                        b_q   <= grant_id ? req1_b  : req0_b;
                        op_q  <= grant_id ? req1_op : req0_op;
                        id_q  <= grant_id;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= result;
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        ptr       <= ~res_id;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lu_arbiter.sv
// tb_lu_arbiter: directed self-checking bench for lu_arbiter (WIDTH = 4).
// Inputs are driven and registered outputs sampled on the falling edge;
// combinational readys are sampled 1 ns after driving.
module tb_lu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0] req0_op, req1_op;
    logic       res_valid, res_ready, res_id;
    logic [3:0] res_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lu_arbiter #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One transaction from requester 'who' with res_ready held high.
    // Called at a falling edge while the DUT is idle or about to be.
    task automatic txn(input bit who, input logic [1:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] exp);
        bit seen = 1'b0;
        if (who) begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((who ? req1_ready : req0_ready) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept", {31'd0, seen}, 32'd1);
        if (seen)
            check("other_ready", {31'd0, who ? req0_ready : req1_ready}, 32'd0);
        @(negedge clk);
        if (who) req1_valid = 1'b0; else req0_valid = 1'b0;
        check("exec_valid", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        check("hold_valid", {31'd0, res_valid}, 32'd1);
        check("hold_data", {28'd0, res_data}, {28'd0, exp});
        check("hold_id", {31'd0, res_id}, {31'd0, who});
        @(negedge clk);
        check("done_valid", {31'd0, res_valid}, 32'd0);
    endtask

    initial begin
        int gnt[4];
        int cyc[4];
        int n;

        rst_n      = 1'b0;
        res_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = 4'b1100; req0_b = 4'b1010; req0_op = 2'b01;
        req1_valid = 1'b1; req1_a = 4'b1100; req1_b = 4'b1010; req1_op = 2'b00;

        // Reset values; readys held low during reset even with requests pending.
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_data", {28'd0, res_data}, 32'd0);
        check("rst_id", {31'd0, res_id}, 32'd0);
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_ready1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First cycle after release: both valid, pointer starts at req0.
        txn(1'b0, 2'b01, 4'b1100, 4'b1010, 4'b1000);

        // All four ops through requester 1.
        txn(1'b1, 2'b00, 4'b1100, 4'b1010, 4'b0111);
        txn(1'b1, 2'b01, 4'b1100, 4'b1010, 4'b1000);
        txn(1'b1, 2'b10, 4'b1100, 4'b1010, 4'b1110);
        txn(1'b1, 2'b11, 4'b1100, 4'b1010, 4'b0001);

        // Round robin: both held valid; pointer is back at req0.
        req0_valid = 1'b1; req0_op = 2'b01;
        req1_valid = 1'b1; req1_op = 2'b10;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
                gnt[n] = (req1_ready === 1'b1) ? 1 : 0;
                cyc[n] = c;
                n++;
            end
            @(negedge clk);
            if (n == 4) break;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("rr_count", n, 4);
        for (int i = 0; i < n; i++) begin
            check("rr_order", gnt[i], i % 2);
            if (i > 0) check("rr_spacing", cyc[i] - cyc[i-1], 3);
        end
        repeat (2) @(negedge clk);

        // Back-pressure: req0 NAND, req1 waiting behind it.
        res_ready  = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 4'b1100; req0_b = 4'b1010;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 4'b1100; req1_b = 4'b1010;
        #1;
        check("bp_accept0", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, res_valid}, 32'd1);
            check("bp_data", {28'd0, res_data}, 32'h7);
            check("bp_id", {31'd0, res_id}, 32'd0);
            check("bp_ready0", {31'd0, req0_ready}, 32'd0);
            check("bp_ready1", {31'd0, req1_ready}, 32'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_released", {31'd0, res_valid}, 32'd0);
        check("bp_next_grant1", {31'd0, req1_ready}, 32'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        res_ready  = 1'b0;
        @(negedge clk);
        check("pre_rst_data", {28'd0, res_data}, 32'h7);
        check("pre_rst_valid", {31'd0, res_valid}, 32'd1);

        // Asynchronous reset in HOLD, away from any clock edge.
        req1_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, res_valid}, 32'd0);
        check("arst_data", {28'd0, res_data}, 32'd0);
        check("arst_id", {31'd0, res_id}, 32'd0);
        check("arst_ready1", {31'd0, req1_ready}, 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        res_ready  = 1'b1;
        req1_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("no_result", {31'd0, res_valid}, 32'd0);
        end
        txn(1'b1, 2'b10, 4'b0011, 4'b0101, 4'b0111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
